// File: rtl/ram_loader.sv
// Boot loader in front of RAM port A: parses A5/LEN/ADR/payload/CSUM frames, writes LE words,
// and releases the CPU on a good checksum. Optional inter-byte timeout under LOADER_TIMEOUT_EN.
module ram_loader #(
    parameter int XADR = 12,
    parameter int TOUT = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic [3:0]      cpu_wen,
    input  logic [XADR-1:0] cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic [3:0]      ram_wen,
    output logic [XADR-1:0] ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata,
    output logic            cpu_rst_n,
    output logic            err
);

    typedef enum logic [2:0] {SYNC, LEN0, LEN1, ADR0, ADR1, DATA, CSUM, DONE} state_t;

    state_t          state;
    logic [15:0]     len;
    logic [XADR-1:0] addr;
    logic [23:0]     word;
    logic [1:0]      bidx;
    logic [7:0]      xsum;
    logic [3:0]      ld_wen;
    logic [XADR-1:0] ld_addr;
    logic [31:0]     ld_wdata;
    logic            acc;
    logic            tmo;

    assign in_ready = (state != DONE);
    assign acc      = in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
    logic [TOUT-1:0] idle;

    // Fires on the 2^TOUT-th consecutive idle cycle inside a frame.
    assign tmo = (state != SYNC) && (state != DONE) && !acc && (&idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle <= '0;
        else if (state == SYNC || state == DONE || acc)
            idle <= '0;
        else
            idle <= idle + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SYNC;
            len       <= '0;
            addr      <= '0;
            word      <= '0;
            bidx      <= '0;
            xsum      <= '0;
            ld_wen    <= '0;
            ld_addr   <= '0;
            ld_wdata  <= '0;
            cpu_rst_n <= 1'b0;
            err       <= 1'b0;
        end else begin
            ld_wen <= 4'h0;
            if (tmo) begin
                state <= SYNC;
                err   <= 1'b1;
            end else if (acc) begin
                case (state)
                    SYNC: if (in_data == 8'hA5) begin
                        state <= LEN0;
                        xsum  <= '0;
                        bidx  <= '0;
                        err   <= 1'b0;
                    end
                    LEN0: begin
                        word[7:0] <= in_data;
                        state     <= LEN1;
                    end
                    LEN1: begin
                        len   <= {in_data, word[7:0]};
                        state <= ADR0;
                    end
                    ADR0: begin
                        word[7:0] <= in_data;
                        state     <= ADR1;
                    end
                    ADR1: begin
                        // Address bits above XADR are dropped here.
                        addr  <= XADR'({in_data, word[7:0]});
                        bidx  <= '0;
                        state <= (len != 16'd0) ? DATA : CSUM;
                    end
                    DATA: begin
                        xsum <= xsum ^ in_data;
                        word <= {in_data, word[23:8]};
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            ld_wen   <= 4'hF;
                            ld_addr  <= addr;
                            ld_wdata <= {in_data, word};
                            addr     <= addr + 1'b1;
                            len      <= len - 16'd1;
                            if (len == 16'd1)
                                state <= CSUM;
                        end
                    end
                    CSUM: if (in_data == xsum) begin
                        state     <= DONE;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        err   <= 1'b1;
                        state <= SYNC;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Port A belongs to the loader until the CPU is released.
    assign ram_wen   = cpu_rst_n ? cpu_wen   : ld_wen;
    assign ram_addr  = cpu_rst_n ? cpu_addr  : ld_addr;
    assign ram_wdata = cpu_rst_n ? cpu_wdata : ld_wdata;
    assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: directed frames from the test plan plus random frames against a
// frame-level model (expected word writes, checksum outcome) and a RAM model on port A.
module tb_ram_loader;
    localparam int XADR = 12;
    localparam int TOUT = 4;

    logic            clk, rst_n, in_valid, in_ready, cpu_rst_n, err;
    logic [7:0]      in_data;
    logic [3:0]      cpu_wen, ram_wen;
    logic [XADR-1:0] cpu_addr, ram_addr;
    logic [31:0]     cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    ram_loader #(.XADR(XADR), .TOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cpu_rst_n(cpu_rst_n), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with one-cycle read latency
    logic [31:0] mem [0:(1<<XADR)-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_addr];
    end

    // Loader-side write log
    int              obs_n = 0;
    logic [XADR-1:0] obs_a [0:1023];
    logic [31:0]     obs_d [0:1023];
    logic [3:0]      obs_w [0:1023];
    always @(negedge clk) begin
        if (rst_n && !cpu_rst_n && ram_wen != 4'h0) begin
            obs_a[obs_n] <= ram_addr;
            obs_d[obs_n] <= ram_wdata;
            obs_w[obs_n] <= ram_wen;
            obs_n        <= obs_n + 1;
        end
    end

    logic [7:0] pay [0:63];

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cpu_wen = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1; in_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Sends one frame built from pay[] and checks writes, release and err against the model.
    task automatic test_frame(input string nm, input logic [15:0] len, input logic [15:0] adr,
                              input int ngarb, input logic bad, input int maxgap);
        int s0;
        logic [7:0] cs, g;
        logic [XADR-1:0] ea;
        logic [31:0] ed;
        s0 = obs_n;
        for (int i = 0; i < ngarb; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, $urandom_range(0, maxgap));
        end
        cs = 8'h00;
        for (int i = 0; i < int'(len) * 4; i++) cs ^= pay[i];
        if (bad) cs ^= 8'h01;
        send_byte(8'hA5, $urandom_range(0, maxgap));
        n_cmp++;
        if (err !== 1'b0) begin n_err++; $display("FAIL %s err_after_sync got %b want 0", nm, err); end
        send_byte(len[7:0],  $urandom_range(0, maxgap));
        send_byte(len[15:8], $urandom_range(0, maxgap));
        send_byte(adr[7:0],  $urandom_range(0, maxgap));
        send_byte(adr[15:8], $urandom_range(0, maxgap));
        for (int i = 0; i < int'(len) * 4; i++) send_byte(pay[i], $urandom_range(0, maxgap));
        n_cmp++;
        if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL %s early_release got %b want 0", nm, cpu_rst_n); end
        send_byte(cs, 0);
        n_cmp++;
        if (cpu_rst_n !== !bad) begin n_err++; $display("FAIL %s cpu_rst_n got %b want %b", nm, cpu_rst_n, !bad); end
        n_cmp++;
        if (err !== bad) begin n_err++; $display("FAIL %s err got %b want %b", nm, err, bad); end
        n_cmp++;
        if (in_ready !== bad) begin n_err++; $display("FAIL %s in_ready got %b want %b", nm, in_ready, bad); end
        n_cmp++;
        if (obs_n - s0 != int'(len)) begin
            n_err++; $display("FAIL %s write_count got %0d want %0d", nm, obs_n - s0, len);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                ea = XADR'(int'(adr) + i);
                ed = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
                n_cmp++;
                if (obs_a[s0+i] !== ea || obs_d[s0+i] !== ed || obs_w[s0+i] !== 4'hF) begin
                    n_err++;
                    $display("FAIL %s write%0d got %h:%h/%h want %h:%h/f", nm, i,
                             obs_a[s0+i], obs_d[s0+i], obs_w[s0+i], ea, ed);
                end
            end
        end
    endtask

    task automatic load_directed_payload();
        pay[0] = 8'h78; pay[1] = 8'h56; pay[2] = 8'h34; pay[3] = 8'h12;
        pay[4] = 8'hEF; pay[5] = 8'hBE; pay[6] = 8'hAD; pay[7] = 8'hDE;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cpu_wen = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, cpu_rst_n, err, ram_wen} !== {1'b1, 1'b0, 1'b0, 4'h0} || ram_addr !== '0 || ram_wdata !== '0) begin
            n_err++;
            $display("FAIL reset got rdy=%b rst=%b err=%b wen=%h a=%h d=%h want 1 0 0 0 0 0",
                     in_ready, cpu_rst_n, err, ram_wen, ram_addr, ram_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_reset();
        load_directed_payload();
        test_frame("directed", 16'd2, 16'h0010, 0, 1'b0, 0);
    endtask

    task automatic test_passthrough();
        cpu_wen = 4'h3; cpu_addr = 12'h020; cpu_wdata = 32'hAABBCCDD;
        #1;
        n_cmp++;
        if (ram_wen !== 4'h3 || ram_addr !== 12'h020 || ram_wdata !== 32'hAABBCCDD) begin
            n_err++; $display("FAIL passthru got %h:%h:%h want 3:020:aabbccdd", ram_wen, ram_addr, ram_wdata);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL passthru_ready got %b want 0", in_ready); end
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0; cpu_wen = 4'h0;
        n_cmp++;
        if (cpu_rst_n !== 1'b1 || err !== 1'b0) begin
            n_err++; $display("FAIL passthru_ignore got rst=%b err=%b want 1 0", cpu_rst_n, err);
        end
        cpu_addr = 12'h010;
        @(posedge clk); #1;
        n_cmp++;
        if (cpu_rdata !== 32'h12345678) begin n_err++; $display("FAIL rdata10 got %h want 12345678", cpu_rdata); end
        cpu_addr = 12'h020;
        @(posedge clk); #1;
        n_cmp++;
        if (cpu_rdata[15:0] !== 16'hCCDD) begin n_err++; $display("FAIL rdata20 got %h want ccdd", cpu_rdata[15:0]); end
    endtask

    task automatic test_bad_csum();
        do_reset();
        load_directed_payload();
        test_frame("bad_csum", 16'd2, 16'h0010, 0, 1'b1, 0);
        test_frame("recover", 16'd2, 16'h0010, 0, 1'b0, 1);
    endtask

    task automatic test_garbage_wrap();
        do_reset();
        send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h5A, 0);
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        test_frame("garbage", 16'd1, 16'h0FFF, 0, 1'b0, 0);
    endtask

    task automatic test_len0();
        do_reset();
        test_frame("len0", 16'd0, 16'h0000, 0, 1'b0, 0);
    endtask

    task automatic test_midreset();
        int s0;
        do_reset();
        s0 = obs_n;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h05, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, cpu_rst_n, err, ram_wen} !== {1'b1, 1'b0, 1'b0, 4'h0} || ram_addr !== '0 || ram_wdata !== '0) begin
            n_err++;
            $display("FAIL midreset got rdy=%b rst=%b err=%b wen=%h a=%h d=%h want 1 0 0 0 0 0",
                     in_ready, cpu_rst_n, err, ram_wen, ram_addr, ram_wdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_n !== s0) begin n_err++; $display("FAIL midreset_write got %0d writes want 0", obs_n - s0); end
        for (int i = 0; i < 12; i++) pay[i] = 8'($urandom);
        test_frame("after_reset", 16'd3, 16'h0005, 0, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [15:0] len, adr;
        logic bad;
        for (int n = 0; n < 8; n++) begin
            do_reset();
            len = 16'($urandom_range(1, 6));
            adr = 16'($urandom);
            if (n == 0) adr = 16'hFFFE;
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < int'(len) * 4; i++) pay[i] = 8'($urandom);
            test_frame("random", len, adr, $urandom_range(0, 3), bad, 2);
        end
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int s0;
        do_reset();
        s0 = obs_n;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h30, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 20);
        n_cmp++;
        if (err !== 1'b1 || cpu_rst_n !== 1'b0) begin
            n_err++; $display("FAIL timeout got err=%b rst=%b want 1 0", err, cpu_rst_n);
        end
        n_cmp++;
        if (obs_n !== s0) begin n_err++; $display("FAIL timeout_write got %0d writes want 0", obs_n - s0); end
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        test_frame("after_timeout", 16'd1, 16'h0030, 0, 1'b0, 1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_passthrough();
        test_bad_csum();
        test_garbage_wrap();
        test_len0();
        test_midreset();
        test_random();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
